serial_vedic_subtractor: RTL and testbench

- Bit-serial N-bit subtractor. Computes in1 - in2 - bin, one bit per clock, using a registered borrow.
- It is the inverse-direction counterpart of the ripple Vedic adder chain and sits beside it in the approximate arithmetic datapath.
- Operands are accepted, and results returned, through valid/ready handshakes.
- An optional approximate mode drops borrow logic in the low bits.

---
 rtl/serial_vedic_subtractor.sv | 153 +++++++++++++++
 tb/tb_serial_vedic_subtractor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_vedic_subtractor.sv
// serial_vedic_subtractor
// Bit-serial WIDTH-bit subtractor computing in1 - in2 - bin, LSB first, one
// bit per clock through a registered borrow. Operands arrive and results
// leave over valid/ready handshakes; operations never overlap.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in1, in2   minuend, subtrahend (WIDTH bits)
//   bin        borrow-in
//   in_valid   operands valid           in_ready   block can accept operands
//   diff       difference (registered)  bout       borrow-out (registered)
//   out_valid  diff/bout valid          out_ready  consumer accepts result
//
// Build option: define APPROX_LSB_EN to compute the low APPROX_BITS bits as
// a^b with the borrow held at bin; exact borrow chaining resumes above them.
module serial_vedic_subtractor #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned APPROX_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Elaboration-time parameter sanity check.
    if (WIDTH < 2 || APPROX_BITS > WIDTH) begin : g_bad_params
        $error("serial_vedic_subtractor: need WIDTH >= 2 and APPROX_BITS <= WIDTH");
    end

    logic [1:0]       state,  state_n;
    logic [WIDTH-1:0] a_sr,   a_n;
    logic [WIDTH-1:0] b_sr,   b_n;
    logic [WIDTH-1:0] r_sr,   r_n;
    logic             br,     br_n;
    logic [CW-1:0]    cnt,    cnt_n;
    logic [WIDTH-1:0] diff_n;
    logic             bout_n;
    logic             out_valid_n;
    logic             in_ready_n;
    logic             a_bit, b_bit, d_bit, br_nx;
    logic             last;

    // Next-state, datapath and output logic.
    always_comb begin
        state_n     = state;
        a_n         = a_sr;
        b_n         = b_sr;
        r_n         = r_sr;
        br_n        = br;
        cnt_n       = cnt;
        diff_n      = diff;
        bout_n      = bout;
        out_valid_n = out_valid;

        a_bit = a_sr[0];
        b_bit = b_sr[0];
        last  = (cnt == CW'(WIDTH - 1));

        // Full-subtractor bit slice.
        d_bit = a_bit ^ b_bit ^ br;
        br_nx = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
`ifdef APPROX_LSB_EN
        // Low bits ignore the borrow chain; the register keeps bin for them.
        if (int'(cnt) < int'(APPROX_BITS)) begin
            d_bit = a_bit ^ b_bit;
            br_nx = br;
        end
`endif

        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    a_n     = in1;
                    b_n     = in2;
                    br_n    = bin;
                    r_n     = '0;
                    cnt_n   = '0;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                a_n   = a_sr >> 1;
                b_n   = b_sr >> 1;
                r_n   = {d_bit, r_sr[WIDTH-1:1]};
                br_n  = br_nx;
                cnt_n = cnt + CW'(1);
                if (last) begin
                    diff_n      = {d_bit, r_sr[WIDTH-1:1]};
                    bout_n      = br_nx;
                    out_valid_n = 1'b1;
                    cnt_n       = '0;
                    state_n     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = S_IDLE;
                end
            end
            default: begin
                out_valid_n = 1'b0;
                state_n     = S_IDLE;
            end
        endcase

        // Ready is registered, so it is raised for the cycle we will be idle in.
        in_ready_n = (state_n == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            r_sr      <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_n;
            a_sr      <= a_n;
            b_sr      <= b_n;
            r_sr      <= r_n;
            br        <= br_n;
            cnt       <= cnt_n;
            diff      <= diff_n;
            bout      <= bout_n;
            out_valid <= out_valid_n;
            in_ready  <= in_ready_n;
        end
    end

endmodule

// File: tb/tb_serial_vedic_subtractor.sv
// tb_serial_vedic_subtractor
// Directed self-checking bench for serial_vedic_subtractor (WIDTH=4). Each
// vector carries hand-computed results for both the exact build and the
// APPROX_LSB_EN build (APPROX_BITS=2); the matching one is selected.
module tb_serial_vedic_subtractor;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in1, in2;
    logic         bin;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         out_valid;
    logic         out_ready;

    int n_cmp = 0;
    int n_err = 0;

    serial_vedic_subtractor #(.WIDTH(W), .APPROX_BITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with out_ready held high.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bi, input logic [W-1:0] ed_ex, input logic eb_ex,
                         input logic [W-1:0] ed_ap, input logic eb_ap);
        int k;
        logic [W-1:0] ed;
        logic         eb;
`ifdef APPROX_LSB_EN
        ed = ed_ap; eb = eb_ap;
`else
        ed = ed_ex; eb = eb_ex;
`endif
        k = 0;
        while (!in_ready && k < 20) begin tick(); k++; end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in1 = a; in2 = b; bin = bi; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        k = 0;
        while (!out_valid && k < 20) begin tick(); k++; end
        check({tag, "_latency"}, 32'(k), 32'(W));
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
        tick();
        check({tag, "_ovclr"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] bb_a  [3];
        logic [W-1:0] bb_b  [3];
        logic         bb_bi [3];
        logic [W-1:0] bb_d  [3];
        logic         bb_bo [3];
        int           k, got, idx, last_cyc;
        logic         pre_rdy;

        rst = 1'b1; in1 = '0; in2 = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Directed vectors: exact / approximate expectations.
        do_op("sub_9_3",   4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 4'd10, 1'b0);
        do_op("sub_3_9",   4'd3,  4'd9,  1'b0, 4'd10, 1'b1, 4'd10, 1'b1);
        do_op("sub_0_0_1", 4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 4'd12, 1'b1);
        do_op("sub_15_15", 4'd15, 4'd15, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0);
        do_op("sub_4_1",   4'd4,  4'd1,  1'b0, 4'd3,  1'b0, 4'd5,  1'b0);
        do_op("sub_8_4",   4'd8,  4'd4,  1'b0, 4'd4,  1'b0, 4'd4,  1'b0);

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        in1 = 4'd7; in2 = 4'd2; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin tick(); k++; end
        check("bp_latency", 32'(k), 32'(W));
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1'b1; in1 = 4'd1; in2 = 4'd1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("bp_diff", 32'(diff), 32'd5);
            check("bp_bout", 32'(bout), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_ov", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_diff_held", 32'(diff), 32'd5);
        tick();
        check("bp_no_ghost_op", 32'(in_ready), 32'd1);

        // Reset in the middle of RUN discards the operation.
        in1 = 4'd12; in2 = 4'd5; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_ready_after", 32'(in_ready), 32'd1);
        do_op("sub_8_1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 4'd9, 1'b0);

        // Back-to-back with in_valid held high.
        bb_a[0] = 4'd5;  bb_b[0] = 4'd3;  bb_bi[0] = 1'b0;
        bb_a[1] = 4'd1;  bb_b[1] = 4'd2;  bb_bi[1] = 1'b0;
        bb_a[2] = 4'd10; bb_b[2] = 4'd10; bb_bi[2] = 1'b1;
`ifdef APPROX_LSB_EN
        bb_d[0] = 4'd6;  bb_bo[0] = 1'b0;
        bb_d[1] = 4'd3;  bb_bo[1] = 1'b0;
        bb_d[2] = 4'd12; bb_bo[2] = 1'b1;
`else
        bb_d[0] = 4'd2;  bb_bo[0] = 1'b0;
        bb_d[1] = 4'd15; bb_bo[1] = 1'b1;
        bb_d[2] = 4'd15; bb_bo[2] = 1'b1;
`endif
        idx = 0; got = 0; last_cyc = 0;
        in1 = bb_a[0]; in2 = bb_b[0]; bin = bb_bi[0]; in_valid = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 3; cyc++) begin
            pre_rdy = in_ready;
            tick();
            if (pre_rdy && in_valid) begin
                idx++;
                if (idx < 3) begin
                    in1 = bb_a[idx]; in2 = bb_b[idx]; bin = bb_bi[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check("b2b_diff", 32'(diff), 32'(bb_d[got]));
                check("b2b_bout", 32'(bout), 32'(bb_bo[got]));
                check("b2b_no_overlap", 32'(in_ready), 32'd0);
                if (got > 0) check("b2b_spacing", 32'(cyc - last_cyc), 32'(W + 2));
                last_cyc = cyc;
                got++;
            end
        end
        check("b2b_count", 32'(got), 32'd3);
        check("b2b_accepts", 32'(idx), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
